// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display blocks: digit count,
// blanked-segment code, scan states and the hex glyph table.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } scan_state_t;

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] value;
        logic [NUM_DIGITS-1:0]   dp;
    } disp_word_t;

    // Active-low {g,f,e,d,c,b,a}; entry 15 first so HEX_SEG[n] is glyph n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seg_hex_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seven_seg_display_ctrl.sv
// Single-clock 4-digit multiplexed display scanner with dead time,
// leading-zero blanking and a frame-aligned value-update handshake.
module seven_seg_display_ctrl
    import seven_seg_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        value_valid,
    output logic        value_ready,
    input  logic        blank_lz,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW:0]   BLANK_END = (CW + 1)'(BLANK_CYCLES);
    localparam logic [1:0]    IDX_LAST  = 2'(NUM_DIGITS - 1);

    scan_state_t   state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [1:0]    idx;
    disp_word_t    disp;
    disp_word_t    pend;
    logic          frame_end;
    logic          drive;

    logic [NUM_DIGITS-1:0][6:0] dig_seg;
    logic [NUM_DIGITS-1:0]      lz;

    // One decoder per digit; a digit above 0 is blanked when it and every
    // more significant nibble are zero.
    genvar k;
    generate
        for (k = 0; k < NUM_DIGITS; k++) begin : g_digit
            seg_hex_decoder u_dec (
                .nibble (disp.value[4*k +: 4]),
                .seg    (dig_seg[k])
            );
            if (k == 0) begin : g_d0
                assign lz[k] = 1'b0;
            end else begin : g_dn
                assign lz[k] = blank_lz && (disp.value[4*NUM_DIGITS-1:4*k] == '0);
            end
        end
    endgenerate

    always_comb begin
        cnt_next = cnt + CW'(1);
        if (state == IDLE || cnt == CNT_LAST)
            cnt_next = '0;
    end

    assign frame_end = enable && (state != IDLE) && (cnt == CNT_LAST) && (idx == IDX_LAST);
    // Gating on the live enable darkens the pins on the same edge that sees it drop.
    assign drive = enable && (state == DRIVE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            disp        <= '0;
            pend        <= '0;
            value_ready <= 1'b1;
            anode       <= '1;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            frame_tick  <= 1'b0;
        end else begin
            if (!enable) begin
                state <= IDLE;
                cnt   <= '0;
                idx   <= '0;
            end else begin
                cnt   <= cnt_next;
                state <= ({1'b0, cnt_next} < BLANK_END) ? BLANK : DRIVE;
                if (state != IDLE && cnt == CNT_LAST)
                    idx <= idx + 2'd1;
            end

            frame_tick <= frame_end;

            // value_ready low means pend holds an uncommitted word.
            if (!value_ready && (state == IDLE || frame_end)) begin
                disp        <= pend;
                value_ready <= 1'b1;
            end else if (value_valid && value_ready) begin
                pend        <= {value, dp_in};
                value_ready <= 1'b0;
            end

            anode <= drive ? ~(4'b0001 << idx) : 4'hF;
            seg   <= (drive && !lz[idx]) ? dig_seg[idx] : SEG_OFF;
            dp    <= drive ? ~disp.dp[idx] : 1'b1;
        end
    end

endmodule
